// File: rtl/conv3x3_mac_sequencer.sv
// rtl/conv3x3_mac_sequencer.sv - 3x3 convolution sequencer driving a shared 3-lane MAC
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, kernel       frame start (sampled in IDLE) and 9 x 8-bit weights, latched on start
//   busy, done          frame in progress / one-cycle completion pulse
//   rd_en, rd_addr      pixel memory read request (row*IMG_W + col)
//   rd_data             read data, valid the cycle after rd_en
//   mac_reset           MAC accumulator clear
//   mac_data            pixel lanes {col2, col1, col0}
//   mac_weight          weight lanes for the current kernel row
//   mac_result          MAC accumulator value
//   out_valid/out_ready output handshake
//   out_pixel           saturated (out_raw >> SHIFT)
//   out_raw             captured MAC sum
//   out_x, out_y        top-left corner of the window being delivered
module conv3x3_mac_sequencer #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16,
  parameter int SHIFT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [71:0]       kernel,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              mac_reset,
  output logic [23:0]       mac_data,
  output logic [23:0]       mac_weight,
  input  logic [15:0]       mac_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_pixel,
  output logic [15:0]       out_raw,
  output logic [ADDR_W-1:0] out_x,
  output logic [ADDR_W-1:0] out_y
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_F0,
    S_F1,
    S_F2,
    S_LAND,
    S_ISSUE,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] X_LAST  = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] Y_LAST  = ADDR_W'(IMG_H - 3);

  state_t            state_q, state_d;
  logic [71:0]       kernel_q, kernel_d;
  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] y_q, y_d;
  logic [1:0]        r_q, r_d;
  logic [7:0]        lane0_q, lane0_d;
  logic [7:0]        lane1_q, lane1_d;
  logic [7:0]        lane2_q, lane2_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              mac_reset_q, mac_reset_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       out_raw_q, out_raw_d;
  logic [7:0]        out_pixel_q, out_pixel_d;

  logic [15:0]       scaled;
  logic [ADDR_W-1:0] col_d;

  assign scaled = mac_result >> SHIFT;

  always_comb begin
    state_d     = state_q;
    kernel_d    = kernel_q;
    x_d         = x_q;
    y_d         = y_q;
    r_d         = r_q;
    lane0_d     = lane0_q;
    lane1_d     = lane1_q;
    lane2_d     = lane2_q;
    out_raw_d   = out_raw_q;
    out_pixel_d = out_pixel_q;

    // Read data trails rd_en by one cycle, so each column lands one state later.
    if (state_q == S_F1)   lane0_d = rd_data;
    if (state_q == S_F2)   lane1_d = rd_data;
    if (state_q == S_LAND) lane2_d = rd_data;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          kernel_d = kernel;
          x_d      = '0;
          y_d      = '0;
          r_d      = 2'd0;
          state_d  = S_F0;
        end
      end
      S_F0:   state_d = S_F1;
      S_F1:   state_d = S_F2;
      S_F2:   state_d = S_LAND;
      S_LAND: state_d = S_ISSUE;
      S_ISSUE: begin
        if (r_q == 2'd2) begin
          // The MAC added the last row on the falling edge inside ISSUE.
          out_raw_d   = mac_result;
          out_pixel_d = (scaled > 16'd255) ? 8'hFF : scaled[7:0];
          state_d     = S_OUT;
        end else begin
          r_d     = r_q + 2'd1;
          state_d = S_F0;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          r_d = 2'd0;
          if (x_q < X_LAST) begin
            x_d     = x_q + 1'b1;
            state_d = S_F0;
          end else if (y_q < Y_LAST) begin
            x_d     = '0;
            y_d     = y_q + 1'b1;
            state_d = S_F0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are decoded from the state being entered so they
    // line up with that state for its whole cycle.
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    out_valid_d = (state_d == S_OUT);
    mac_reset_d = !(state_d inside {S_F0, S_F1, S_F2, S_LAND, S_ISSUE});
    rd_en_d     = state_d inside {S_F0, S_F1, S_F2};

    case (state_d)
      S_F1:    col_d = ADDR_W'(1);
      S_F2:    col_d = ADDR_W'(2);
      default: col_d = '0;
    endcase

    if (rd_en_d) begin
      rd_addr_d = (y_d + {{(ADDR_W-2){1'b0}}, r_d}) * IMG_W_A + x_d + col_d;
    end else begin
      rd_addr_d = rd_addr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kernel_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      r_q         <= 2'd0;
      lane0_q     <= '0;
      lane1_q     <= '0;
      lane2_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      mac_reset_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_raw_q   <= '0;
      out_pixel_q <= '0;
    end else begin
      state_q     <= state_d;
      kernel_q    <= kernel_d;
      x_q         <= x_d;
      y_q         <= y_d;
      r_q         <= r_d;
      lane0_q     <= lane0_d;
      lane1_q     <= lane1_d;
      lane2_q     <= lane2_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      mac_reset_q <= mac_reset_d;
      out_valid_q <= out_valid_d;
      out_raw_q   <= out_raw_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  // The MAC accumulates on every falling edge it is not cleared, so the lanes
  // are forced to zero outside ISSUE.
  assign mac_data = (state_q == S_ISSUE) ? {lane2_q, lane1_q, lane0_q} : 24'd0;

  always_comb begin
    mac_weight = 24'd0;
    if (state_q == S_ISSUE) begin
      case (r_q)
        2'd0:    mac_weight = kernel_q[23:0];
        2'd1:    mac_weight = kernel_q[47:24];
        2'd2:    mac_weight = kernel_q[71:48];
        default: mac_weight = 24'd0;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign mac_reset = mac_reset_q;
  assign out_valid = out_valid_q;
  assign out_raw   = out_raw_q;
  assign out_pixel = out_pixel_q;
  assign out_x     = x_q;
  assign out_y     = y_q;

endmodule

// File: tb/tb_conv3x3_mac_sequencer.sv
// tb/tb_conv3x3_mac_sequencer.sv - scoreboard bench for conv3x3_mac_sequencer (4x4/SHIFT0 and 8x8/SHIFT4)
module tb_conv3x3_mac_sequencer;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] raw;
    logic [7:0]  pix;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_v     [2];
  logic        out_ready_v [2];
  logic        busy_v      [2];
  logic        done_v      [2];
  logic        rd_en_v     [2];
  logic        mac_reset_v [2];
  logic        out_valid_v [2];
  logic [71:0] kernel_v    [2];
  logic [15:0] rd_addr_v   [2];
  logic [15:0] mac_result_v[2];
  logic [15:0] out_raw_v   [2];
  logic [15:0] out_x_v     [2];
  logic [15:0] out_y_v     [2];
  logic [15:0] acc         [2];
  logic [7:0]  rd_data_v   [2];
  logic [7:0]  out_pixel_v [2];
  logic [23:0] mac_data_v  [2];
  logic [23:0] mac_weight_v[2];
  logic [7:0]  mem [2][64];

  exp_t        sb[$];
  logic [15:0] addr_log[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W  = (g == 0) ? 4 : 8;
    localparam int SH = (g == 0) ? 0 : 4;
    conv3x3_mac_sequencer #(
      .IMG_W(W), .IMG_H(W), .ADDR_W(16), .SHIFT(SH)
    ) u_dut (
      .clk(clk), .reset(reset), .start(start_v[g]), .kernel(kernel_v[g]),
      .busy(busy_v[g]), .done(done_v[g]), .rd_en(rd_en_v[g]), .rd_addr(rd_addr_v[g]),
      .rd_data(rd_data_v[g]), .mac_reset(mac_reset_v[g]), .mac_data(mac_data_v[g]),
      .mac_weight(mac_weight_v[g]), .mac_result(mac_result_v[g]),
      .out_valid(out_valid_v[g]), .out_ready(out_ready_v[g]), .out_pixel(out_pixel_v[g]),
      .out_raw(out_raw_v[g]), .out_x(out_x_v[g]), .out_y(out_y_v[g])
    );
    assign mac_result_v[g] = acc[g];
  end

  function automatic logic [15:0] lane_sum(input logic [23:0] d, input logic [23:0] w);
    logic [31:0] s;
    s = 32'd0;
    for (int k = 0; k < 3; k++) s = s + 32'(d[8*k +: 8]) * 32'(w[8*k +: 8]);
    return s[15:0];
  endfunction

  // Byte memory with one-cycle read latency, and a falling-edge MAC.
  always @(posedge clk)
    for (int g = 0; g < 2; g++)
      if (rd_en_v[g]) rd_data_v[g] <= mem[g][rd_addr_v[g][5:0]];

  always @(negedge clk)
    for (int g = 0; g < 2; g++)
      acc[g] <= mac_reset_v[g] ? 16'd0 : acc[g] + lane_sum(mac_data_v[g], mac_weight_v[g]);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_raw(input int g, input int w, input int x, input int y,
                                          input logic [71:0] kern);
    logic [31:0] s;
    s = 32'd0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        s = s + 32'(mem[g][(y + r) * w + x + k]) * 32'(kern[24*r + 8*k +: 8]);
    return s[15:0];
  endfunction

  task automatic fill_mem(input int g, input bit ramp, input logic [7:0] val);
    for (int i = 0; i < 64; i++) mem[g][i] = ramp ? 8'(i) : val;
  endtask

  task automatic check_reset_outputs(input int g, input string pfx);
    chk({pfx, "_busy"}, busy_v[g], 0);
    chk({pfx, "_done"}, done_v[g], 0);
    chk({pfx, "_rd_en"}, rd_en_v[g], 0);
    chk({pfx, "_rd_addr"}, rd_addr_v[g], 0);
    chk({pfx, "_mac_reset"}, mac_reset_v[g], 1);
    chk({pfx, "_mac_data"}, mac_data_v[g], 0);
    chk({pfx, "_mac_weight"}, mac_weight_v[g], 0);
    chk({pfx, "_out_valid"}, out_valid_v[g], 0);
    chk({pfx, "_out_raw"}, out_raw_v[g], 0);
    chk({pfx, "_out_x"}, out_x_v[g], 0);
    chk({pfx, "_out_y"}, out_y_v[g], 0);
  endtask

  // stall_at: index of the output held off for 20 cycles (-1 = none).
  // abort: reset during F1 of the 3rd window. mess: disturb start/kernel while busy.
  task automatic run_frame(input int g, input logic [71:0] kern, input int stall_at,
                           input bit abort, input bit mess);
    int   w, s, cyc, acc_n, stall_n, dones, acc2_cyc, done_cyc;
    bit   seen_valid;
    exp_t e, snap;
    w = (g == 0) ? 4 : 8;
    s = (g == 0) ? 0 : 4;
    sb.delete();
    addr_log.delete();
    for (int y = 0; y <= w - 3; y++)
      for (int x = 0; x <= w - 3; x++) begin
        e.x   = 16'(x);
        e.y   = 16'(y);
        e.raw = ref_raw(g, w, x, y, kern);
        e.pix = ((e.raw >> s) > 16'd255) ? 8'd255 : 8'(e.raw >> s);
        sb.push_back(e);
      end
    acc_n = 0; stall_n = 0; dones = 0; acc2_cyc = -1; done_cyc = -1; seen_valid = 0;
    snap = '0;

    @(negedge clk);
    kernel_v[g] = kern;
    start_v[g] = 1'b1;
    out_ready_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
    cyc = 1;
    if (mess) kernel_v[g] = ~kern;

    while (cyc < 4000) begin
      if (rd_en_v[g]) addr_log.push_back(rd_addr_v[g]);
      if (done_v[g]) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 3) break;
      if (mess) start_v[g] = (cyc == 20 || cyc == 33);
      if (out_valid_v[g] && !seen_valid) begin
        seen_valid = 1;
        if (g == 1) chk("first_valid_latency", cyc - 1, 15);
      end
      if (abort && acc2_cyc >= 0 && cyc == acc2_cyc + 2) begin
        reset = 1'b1;
        #1;
        check_reset_outputs(g, "abort");
        start_v[g] = 1'b0;
        out_ready_v[g] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (done_v[g]) dones++;
          if (i == 0) reset = 1'b0;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_idle_busy", busy_v[g], 0);
        sb.delete();
        return;
      end
      if (out_valid_v[g] && acc_n == stall_at && stall_n < 20) begin
        out_ready_v[g] = 1'b0;
        if (stall_n == 0) begin
          snap = {out_x_v[g], out_y_v[g], out_raw_v[g], out_pixel_v[g]};
        end else begin
          chk("stall_raw", out_raw_v[g], snap.raw);
          chk("stall_pix", out_pixel_v[g], snap.pix);
          chk("stall_x", out_x_v[g], snap.x);
          chk("stall_y", out_y_v[g], snap.y);
        end
        chk("stall_rd_en", rd_en_v[g], 0);
        stall_n++;
      end else begin
        out_ready_v[g] = 1'b1;
      end
      if (out_valid_v[g] && out_ready_v[g]) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_raw", out_raw_v[g], e.raw);
          chk("out_pixel", out_pixel_v[g], e.pix);
          chk("out_x", out_x_v[g], e.x);
          chk("out_y", out_y_v[g], e.y);
        end
        acc_n++;
        if (acc_n == 2) acc2_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready_v[g] = 1'b0;
    start_v[g] = 1'b0;
    chk("frame_finished", done_cyc >= 0, 1);
    chk("done_pulses", dones, 1);
    chk("outputs_left", sb.size(), 0);
    chk("busy_after_done", busy_v[g], 0);
  endtask

  initial begin
    int exp_addr[9];
    exp_addr = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    for (int g = 0; g < 2; g++) begin
      start_v[g] = 1'b0;
      out_ready_v[g] = 1'b0;
      kernel_v[g] = '0;
      fill_mem(g, 1'b0, 8'd0);
    end

    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) check_reset_outputs(g, "reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 4x4 ramp, unit kernel, 20-cycle stall on the 2nd output, start/kernel poked while busy.
    fill_mem(0, 1'b1, 8'd0);
    run_frame(0, {9{8'd1}}, 1, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) chk("first_rd_addr", addr_log[i], exp_addr[i]);
    chk("read_count", addr_log.size(), 36);

    // 8x8 constant 100, Gaussian kernel, SHIFT 4.
    fill_mem(1, 1'b0, 8'd100);
    run_frame(1, {24'h010201, 24'h020402, 24'h010201}, -1, 1'b0, 1'b0);

    // Accumulator wrap and saturation.
    fill_mem(0, 1'b0, 8'd255);
    run_frame(0, {72{1'b1}}, -1, 1'b0, 1'b0);

    // Abort during F1 of the 3rd window, then a clean frame.
    fill_mem(0, 1'b1, 8'd0);
    run_frame(0, {9{8'd1}}, -1, 1'b1, 1'b1);
    run_frame(0, {24'h030201, 24'h010101, 24'h020304}, -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
